mips_div_unit: RTL
==================

// Module: mips_div_unit
// PURPOSE
//   Iterative radix-2 divider for MIPS DIV/DIVU. Operands come straight from
//   the register-file read ports (rdata_a = dividend, rdata_b = divisor).
//   quotient/remainder go to the HI/LO write logic (LO = quotient, HI = remainder).
//   The pipeline stalls on busy.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; the iteration count equals WIDTH
// PORTS
//   clk          in   1      clock, all state on posedge
//   rst          in   1      reset, synchronous, active-high
//   start        in   1      request a divide; sampled only in IDLE or DONE
//   is_signed    in   1      1 = DIV (two's complement), 0 = DIVU
//   cancel       in   1      abort in-flight divide (exception/flush)
//   dividend     in   WIDTH  numerator, from rdata_a
//   divisor      in   WIDTH  denominator, from rdata_b
//   busy         out  1      high while iterating (state BUSY)
//   done         out  1      one-cycle pulse: results valid this cycle
//   quotient     out  WIDTH  result, held until next accepted start
//   remainder    out  WIDTH  result, held until next accepted start
//   div_by_zero  out  1      divisor was 0 on the last accepted start; held
// BEHAVIOUR
//   Reset: state = IDLE; busy, done and div_by_zero = 0; quotient and remainder = 0.
//     Reset wins over every other input, including in mid-operation.
//   FSM states: IDLE, BUSY, DONE.
//     IDLE -> BUSY   when start & ~cancel & divisor != 0
//     IDLE -> DONE   when start & ~cancel & divisor == 0
//     BUSY -> BUSY   while iteration count < WIDTH
//     BUSY -> DONE   after the WIDTH-th iteration
//     BUSY -> IDLE   on cancel (also overrides the final iteration)
//     DONE -> BUSY/DONE  on start, same rules as IDLE (back-to-back issue)
//     DONE -> IDLE   otherwise
//   Accept, cycle T: latch the operand magnitudes.
//     For signed operation, a negative operand is replaced by its two's-complement
//     negation, computed at WIDTH bits.
//     Latch sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend).
//     Clear the iteration counter and the partial remainder (WIDTH+1 bits).
//   Iterations:
//     One restoring shift-subtract step per cycle, in cycles T+1 .. T+WIDTH.
//     busy = 1 in exactly these WIDTH cycles.
//   Completion, cycle T+WIDTH+1:
//     state = DONE, done = 1, busy = 0.
//     Results are sign-corrected: quotient is negated if sign_q; remainder is
//     negated if sign_r. Both are registered and stay stable from T+WIDTH+1 on.
//   Divide by zero: done is asserted at T+1 with div_by_zero = 1,
//     quotient = 0 and remainder = the dividend as given. There are no iterations.
//   Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and
//     remainder 0. This is natural wrap; no flag is raised.
//   Ignored inputs:
//     start while BUSY is ignored, with no queueing.
//     Operand changes after accept have no effect.
//   Cancel:
//     In BUSY: go to IDLE next cycle and never pulse done. quotient, remainder
//       and div_by_zero keep their pre-accept values.
//     cancel together with start in IDLE/DONE: cancel wins and start is dropped.
//     cancel in DONE: the done pulse of that cycle still stands.
//   div_by_zero updates only on an accepted start.
// TESTING
//   1. DIVU 100/7, start at T -> busy T+1..T+32; done at T+33; q=14, r=2.
//   2. DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//      DIV 7/-2 -> q=0xFFFFFFFD, r=1.
//   3. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//      DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//   4. DIVU 5/0 -> done at T+1, div_by_zero=1, q=0, r=5.
//      Next DIVU 9/3 -> div_by_zero=0, q=3, r=0.
//   5. cancel at T+10 -> busy=0 at T+11, no done, q/r unchanged.
//      start at T+5 while BUSY -> ignored, first op completes normally.
//   6. rst at T+20 -> all outputs 0 next cycle.
//      start in the DONE cycle -> busy next cycle, second result correct.

Source files
------------

// File: rtl/mips_div_unit.sv
// Iterative restoring radix-2 divider for MIPS DIV/DIVU.
// LO takes the quotient and HI takes the remainder. The pipeline stalls while busy is high.
// An operation needs WIDTH iteration cycles. A zero divisor completes in one cycle.
module mips_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;      // dividend magnitude; quotient bits shift in at the bottom
   logic [WIDTH-1:0] dvs;      // divisor magnitude
   logic [WIDTH-1:0] rem;      // partial remainder, always below dvs
   logic             sign_q;
   logic             sign_r;

   logic             accept;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // Two's-complement negation at WIDTH bits. The most negative value maps to itself,
   // and that is also its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic s);
      return s ? (~v + 1'b1) : v;
   endfunction

   assign accept = start && !cancel && (state != BUSY);
   assign a_neg  = is_signed && dividend[WIDTH-1];
   assign b_neg  = is_signed && divisor[WIDTH-1];

   // Restoring step: shift in the next dividend bit, then subtract the divisor if it fits.
   assign rem_sh  = {rem, dvd[WIDTH-1]};
   assign diff    = rem_sh - {1'b0, dvs};
   assign q_bit   = ~diff[WIDTH];
   assign rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nxt = {dvd[WIDTH-2:0], q_bit};

   // Control FSM with registered status outputs and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  cnt <= '0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     div_by_zero <= 1'b1;
                     quotient    <= '0;
                     remainder   <= dividend;
                  end else begin
                     state <= BUSY;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            BUSY: begin
               if (cancel) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == LAST_CNT) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  div_by_zero <= 1'b0;
                  quotient    <= neg_if(quo_nxt, sign_q);
                  remainder   <= neg_if(rem_nxt, sign_r);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: load the magnitudes on accept, then run one shift-subtract step per BUSY cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd    <= neg_if(dividend, a_neg);
         dvs    <= neg_if(divisor, b_neg);
         rem    <= '0;
         sign_q <= a_neg ^ b_neg;
         sign_r <= a_neg;
      end else if (state == BUSY) begin
         dvd <= quo_nxt;
         rem <= rem_nxt;
      end
   end

endmodule
